// File: rtl/seq_alu_wb.sv
// seq_alu_wb: execute stage between the register file read ports and its
// write port. Logic/arithmetic/shift ops complete in one cycle; MUL runs a
// shift-add loop over WIDTH cycles. A start/busy/done handshake talks to the
// sequencing FSM, and the Z/N/C flags are latched alongside each result.
module seq_alu_wb #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    DestAdrs,
    input  logic [WIDTH-1:0] OperA,
    input  logic [WIDTH-1:0] OperB,
    output logic [WIDTH-1:0] WtData,
    output logic [AW-1:0]    WtAdrs,
    output logic             write,
    output logic             busy,
    output logic             done,
    output logic             Z,
    output logic             N,
    output logic             C
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    // Iteration counter only needs to reach WIDTH-1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        WB   = 2'b10
    } state_t;

    state_t           state;

    // Multiplier working registers: multiplicand shifts left, multiplier
    // shifts right, accumulator keeps only the low WIDTH bits of the product.
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [AW-1:0]    dest_reg;

    // Single-cycle ALU outputs, evaluated on the live operands so that the
    // result is captured on the same edge that samples start.
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic [WIDTH:0]   ext_sum;
    logic [WIDTH:0]   ext_shl;
    logic [WIDTH:0]   ext_shr;
    logic [3:0]       sh_amt;
    logic [WIDTH-1:0] acc_next;

    // Combinational single-cycle ALU with carry/borrow/shift-out flag.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        sh_amt  = OperB[3:0];
        ext_sum = '0;
        // A zero guard bit above (SHL) or below (SHR) the operand catches
        // the last bit shifted out; a zero amount leaves the guard at 0.
        ext_shl = {1'b0, OperA} << sh_amt;
        ext_shr = {OperA, 1'b0} >> sh_amt;
        case (op)
            OP_ADD: begin
                ext_sum = {1'b0, OperA} + {1'b0, OperB};
                alu_res = ext_sum[WIDTH-1:0];
                alu_c   = ext_sum[WIDTH];
            end
            OP_SUB: begin
                // Top bit of the extended difference is the borrow (A < B).
                ext_sum = {1'b0, OperA} - {1'b0, OperB};
                alu_res = ext_sum[WIDTH-1:0];
                alu_c   = ext_sum[WIDTH];
            end
            OP_AND: alu_res = OperA & OperB;
            OP_OR:  alu_res = OperA | OperB;
            OP_XOR: alu_res = OperA ^ OperB;
            OP_SHL: begin
                alu_res = ext_shl[WIDTH-1:0];
                alu_c   = ext_shl[WIDTH];
            end
            OP_SHR: begin
                alu_res = ext_shr[WIDTH:1];
                alu_c   = ext_shr[0];
            end
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
            end
        endcase
    end

    // One shift-add step: add the multiplicand when the multiplier LSB is set.
    always_comb begin
        acc_next = mul_b[0] ? (acc + mul_a) : acc;
    end

    // Sequencing FSM with registered result, flags and handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            WtData   <= '0;
            WtAdrs   <= '0;
            write    <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            Z        <= 1'b0;
            N        <= 1'b0;
            C        <= 1'b0;
            mul_a    <= '0;
            mul_b    <= '0;
            acc      <= '0;
            cnt      <= '0;
            dest_reg <= '0;
        end else begin
            // Write strobe and completion pulse are one cycle wide by default.
            write <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (op == OP_MUL) begin
                            mul_a    <= OperA;
                            mul_b    <= OperB;
                            acc      <= '0;
                            cnt      <= '0;
                            dest_reg <= DestAdrs;
                            state    <= EXEC;
                        end else begin
                            WtData <= alu_res;
                            WtAdrs <= DestAdrs;
                            Z      <= (alu_res == '0);
                            N      <= alu_res[WIDTH-1];
                            C      <= alu_c;
                            write  <= 1'b1;
                            done   <= 1'b1;
                            state  <= WB;
                        end
                    end
                end
                EXEC: begin
                    acc   <= acc_next;
                    mul_a <= mul_a << 1;
                    mul_b <= mul_b >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        WtData <= acc_next;
                        WtAdrs <= dest_reg;
                        Z      <= (acc_next == '0);
                        N      <= acc_next[WIDTH-1];
                        C      <= 1'b0;
                        write  <= 1'b1;
                        done   <= 1'b1;
                        state  <= WB;
                    end
                end
                WB: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
